// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : State, opcode and datapath-select encodings shared by the
//            multicycle control FSM, its wait timer and its bus interface.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Debug-visible state encoding (state_o carries these values).
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JUMP_WB  = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  // RV32I major opcodes (instruction[6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Write-back source.
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // ALU operand A.
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_RS1    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC  = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  // ALU operand B.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // PC source.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // ALU operation class.
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  // Trap cause.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Moore control word for one state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic [1:0] memto_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       trap;
  } ctrl_t;

  // Control word asserted while in state s. FETCH carries pc_write/ir_write
  // unconditionally here; the top gates them with mem_ready.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic is_lui);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.pc_write  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_JALR_ADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = MTR_MDR;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_IFUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.memto_reg = MTR_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALU_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP_WB: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALUOUT;
        c.reg_write = 1'b1;
        c.memto_reg = MTR_PC;
      end
      S_UPPER: begin
        c.alu_src_a = is_lui ? SRCA_ZERO : SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm_if
// Purpose  : Instruction/memory-handshake inputs and datapath control outputs
//            of the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;

  logic [31:0] instruction;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        iord;
  logic [1:0]  memto_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic [1:0]  alu_op;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [3:0]  state_o;

  // Controller side.
  modport master (
    input  instruction, mem_ready,
    output pc_write, pc_write_cond, reg_write, mem_read, mem_write,
           ir_write, iord, memto_reg, alu_src_a, alu_src_b, pc_source,
           alu_op, trap, trap_cause, state_o
  );

  // Datapath / memory side.
  modport slave (
    output instruction, mem_ready,
    input  pc_write, pc_write_cond, reg_write, mem_read, mem_write,
           ir_write, iord, memto_reg, alu_src_a, alu_src_b, pc_source,
           alu_op, trap, trap_cause, state_o
  );

endinterface
`default_nettype wire

// File: rtl/mc_control_fsm_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Purpose  : Counts consecutive memory wait cycles and flags the cycle in
//            which the count reaches MEM_TIMEOUT with mem_ready still low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_state,   // FSM is in FETCH, MEMRD or MEMWR
  input  logic mem_ready,
  output logic timeout
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             waiting;

  assign waiting = wait_state & ~mem_ready;

  // Count while stalled; any completed transfer or non-wait state clears,
  // so each wait state is entered with a zero count.
  always_comb begin
    cnt_d = '0;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This cycle would be wait number MEM_TIMEOUT: trap instead of waiting on.
  if (MEM_TIMEOUT == 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_timeout
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);
    assign timeout = waiting & (cnt_q == LIMIT);
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multicycle RV32I control FSM with mem_ready handshake, memory
//            wait timeout, illegal-opcode trap and optional LUI/AUIPC.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit ENABLE_UPPER = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_fsm_if.master   bus
);

  state_e     state_d, state_q;
  logic [1:0] cause_d, cause_q;
  ctrl_t      ctrl_d, ctrl_q;
  ctrl_t      ctrl_out;
  logic [6:0] opcode;
  logic       wait_state;
  logic       timeout;

  assign opcode     = bus.instruction[6:0];
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .wait_state (wait_state),
    .mem_ready  (bus.mem_ready),
    .timeout    (timeout)
  );

  // Next-state and trap-cause selection; mem_ready wins over timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JUMP_WB;
          OP_JALR:            state_d = S_JALR_ADR;
          OP_LUI, OP_AUIPC: begin
            if (ENABLE_UPPER) begin
              state_d = S_UPPER;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R, S_EXEC_I, S_UPPER: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_JUMP_WB: state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JUMP_WB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // IR is stable for the whole instruction, so LUI vs AUIPC can be
    // resolved one cycle early for the registered control word.
    ctrl_d = decode_ctrl(state_d, opcode == OP_LUI);
  end

  // State, trap cause and the registered Moore control word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      ctrl_q  <= decode_ctrl(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Final outputs: FETCH strobes wait for mem_ready, reset forces all low.
  always_comb begin
    ctrl_out = ctrl_q;
    if ((state_q == S_FETCH) && !bus.mem_ready) begin
      ctrl_out.pc_write = 1'b0;
      ctrl_out.ir_write = 1'b0;
    end
    if (rst) begin
      ctrl_out = '0;
    end
  end

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.iord          = ctrl_out.iord;
  assign bus.memto_reg     = ctrl_out.memto_reg;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.trap          = ctrl_out.trap;
  assign bus.trap_cause    = rst ? CAUSE_NONE : cause_q;
  assign bus.state_o       = rst ? 4'd0 : state_q;

endmodule
`default_nettype wire
